// File: rtl/clk_meter.sv
// Measures high time, low time and period (in clk cycles) of an asynchronous waveform.
// Optional duty-cycle tolerance check enabled by defining CLK_METER_DUTY_CHECK_EN.
module clk_meter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned EXP_HIGH    = 5,
    parameter int unsigned EXP_LOW     = 5,
    parameter int unsigned TOL         = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period_cnt,
    output logic             meas_valid,
    output logic [7:0]       meas_num,
    output logic             busy,
    output logic             timeout_err,
    output logic             duty_err
);

    if (SYNC_STAGES < 2 || 64'(TIMEOUT) > ((64'd1 << CNT_W) - 64'd1))
        $error("clk_meter: SYNC_STAGES must be >= 2 and TIMEOUT must fit in CNT_W bits");
    if (EXP_HIGH > TIMEOUT || EXP_LOW > TIMEOUT || TOL > TIMEOUT)
        $error("clk_meter: expected phase times must not exceed TIMEOUT");

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sig_s, sig_d, rise, fall;
    logic [CNT_W-1:0]       cnt, cnt_n, hlat, hlat_n;
    logic                   hit, pub, tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            sig_d <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], sig_in};
            sig_d <= sig_s;
        end
    end

    assign sig_s = sync[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_d;
    assign fall  = ~sig_s & sig_d;
    assign hit   = (cnt == TO_LIM);
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hlat  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            hlat  <= hlat_n;
        end
    end

    // One shared phase counter: ARM wait, then high time, then low time.
    // The awaited edge is tested before the timeout so an edge on the limit cycle wins.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hlat_n  = hlat;
        pub     = 1'b0;
        tmo     = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_n = ARM;
                    cnt_n   = ONE;
                end
            end
            ARM: begin
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (rise) begin
                    state_n = HIGH;
                    cnt_n   = ONE;
                end else if (hit) begin
                    tmo   = 1'b1;
                    cnt_n = ONE;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            HIGH: begin
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (fall) begin
                    state_n = LOW;
                    hlat_n  = cnt;
                    cnt_n   = ONE;
                end else if (hit) begin
                    state_n = ARM;
                    tmo     = 1'b1;
                    cnt_n   = ONE;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            LOW: begin
                if (!enable) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (rise) begin
                    state_n = HIGH;
                    pub     = 1'b1;
                    cnt_n   = ONE;
                end else if (hit) begin
                    state_n = ARM;
                    tmo     = 1'b1;
                    cnt_n   = ONE;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
        endcase
    end

`ifdef CLK_METER_DUTY_CHECK_EN
    function automatic logic out_of_tol(input logic [CNT_W-1:0] v, input int unsigned exp_v);
        int unsigned vv;
        vv = 32'(v);
        return (vv > exp_v + TOL) || (vv + TOL < exp_v);
    endfunction

    logic duty_n;
    always_comb duty_n = out_of_tol(hlat, EXP_HIGH) || out_of_tol(cnt, EXP_LOW);
`else
    assign duty_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_cnt    <= '0;
            low_cnt     <= '0;
            period_cnt  <= '0;
            meas_valid  <= 1'b0;
            meas_num    <= '0;
            timeout_err <= 1'b0;
`ifdef CLK_METER_DUTY_CHECK_EN
            duty_err    <= 1'b0;
`endif
        end else begin
            meas_valid  <= pub;
            timeout_err <= tmo;
            if (pub) begin
                high_cnt   <= hlat;
                low_cnt    <= cnt;
                period_cnt <= {1'b0, hlat} + {1'b0, cnt};
                meas_num   <= meas_num + 8'd1;
`ifdef CLK_METER_DUTY_CHECK_EN
                duty_err   <= duty_n;
`endif
            end
        end
    end

endmodule

// File: tb/tb_clk_meter.sv
// Scoreboard bench for clk_meter: directed waveforms push expected results, a monitor
// pops and compares on every meas_valid.
module tb_clk_meter;

    logic        clk = 1'b0;
    logic        rst_n, enable, sig_in;
    logic [15:0] high_cnt, low_cnt;
    logic [16:0] period_cnt;
    logic        meas_valid, busy, timeout_err, duty_err;
    logic [7:0]  meas_num;

    clk_meter #(
        .CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(1000),
        .EXP_HIGH(5), .EXP_LOW(5), .TOL(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
        .high_cnt(high_cnt), .low_cnt(low_cnt), .period_cnt(period_cnt),
        .meas_valid(meas_valid), .meas_num(meas_num), .busy(busy),
        .timeout_err(timeout_err), .duty_err(duty_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned h;
        int unsigned l;
        int unsigned p;
        int unsigned n;
        logic        d;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_num = 0;
    int          tmo_seen = 0;
    logic        prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic exp_duty(input int unsigned h, input int unsigned l);
`ifdef CLK_METER_DUTY_CHECK_EN
        int unsigned dh, dl;
        dh = (h > 5) ? h - 5 : 5 - h;
        dl = (l > 5) ? l - 5 : 5 - l;
        return (dh > 1) || (dl > 1);
`else
        return 1'b0;
`endif
    endfunction

    // Each level is sampled by exactly n rising edges.
    task automatic drive(input logic lvl, input int n);
        sig_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // push=1 when a later rise will complete this period's measurement.
    task automatic period(input int unsigned h, input int unsigned l, input bit push);
        exp_t e;
        if (push) begin
            exp_num = (exp_num + 1) % 256;
            e.h = h; e.l = l; e.p = h + l; e.n = exp_num; e.d = exp_duty(h, l);
            sb.push_back(e);
        end
        drive(1'b1, int'(h));
        drive(1'b0, int'(l));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_high"},   32'(high_cnt), 0);
        chk({tag, "_low"},    32'(low_cnt), 0);
        chk({tag, "_period"}, 32'(period_cnt), 0);
        chk({tag, "_valid"},  32'(meas_valid), 0);
        chk({tag, "_num"},    32'(meas_num), 0);
        chk({tag, "_busy"},   32'(busy), 0);
        chk({tag, "_tmo"},    32'(timeout_err), 0);
        chk({tag, "_duty"},   32'(duty_err), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (timeout_err) tmo_seen++;
            if (meas_valid) begin
                chk("valid_gap", 32'(prev_valid), 0);
                chk("sb_pending", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("high_cnt",   32'(high_cnt), e.h);
                    chk("low_cnt",    32'(low_cnt), e.l);
                    chk("period_cnt", 32'(period_cnt), e.p);
                    chk("meas_num",   32'(meas_num), e.n);
                    chk("duty_err",   32'(duty_err), 32'(e.d));
                end
            end
            prev_valid = meas_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        drive(1'b0, 2);
        enable = 1'b1;
        drive(1'b0, 3);
        chk("armed_busy", 32'(busy), 1);

        repeat (5)   period(5, 5, 1);
        repeat (257) period(10, 30, 1);
        repeat (6)   period(1, 1, 1);
        period(6, 4, 1);
        period(7, 3, 1);
        period(5, 5, 1);

        // Held high: the rise closes the last period, then the high phase times out.
        drive(1'b1, 1200);
        chk("timeout_pulses", 32'(tmo_seen), 1);
        chk("timeout_busy", 32'(busy), 1);
        drive(1'b0, 5);
        repeat (3) period(5, 5, 1);

        drive(1'b1, 5);
        drive(1'b0, 4);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("dis_busy",   32'(busy), 0);
        chk("dis_high",   32'(high_cnt), 5);
        chk("dis_low",    32'(low_cnt), 5);
        chk("dis_period", 32'(period_cnt), 10);
        chk("dis_num",    32'(meas_num), exp_num);
        drive(1'b0, 3);
        drive(1'b1, 5);
        drive(1'b0, 5);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_num",  32'(meas_num), exp_num);

        enable = 1'b1;
        drive(1'b0, 3);
        repeat (2) period(5, 5, 1);
        drive(1'b1, 6);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        sig_in  = 1'b0;
        sb.delete();
        exp_num = 0;
        drive(1'b0, 3);
        rst_n = 1'b1;
        drive(1'b0, 3);
        period(3, 4, 1);
        period(2, 2, 1);
        drive(1'b1, 4);
        drive(1'b0, 4);

        chk("sb_drained", 32'(sb.size()), 0);
        chk("timeout_total", 32'(tmo_seen), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
